lsu_bus_master: RTL and testbench

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

---
 rtl/lsu_bus_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: turns one MEM-stage access into one or two
// word-aligned bus beats, with byte-lane steering, load extension and a
// per-beat wait timeout.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_e;

  state_e           state_q;
  logic             beat_q;
  logic [CNT_W-1:0] cnt_q;
  logic             write_q;
  logic [2:0]       ltype_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       mask_q;
  logic             misalign_q;
  logic [31:0]      word0_q;
  logic             done_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic             bus_req_q;
  logic             bus_we_q;
  logic [31:0]      bus_addr_q;
  logic [31:0]      bus_wdata_q;
  logic [3:0]       bus_be_q;

  logic [3:0]  mask_c;
  logic        illegal_c;
  logic [7:0]  spill_c;
  logic        misalign_c;
  logic [31:0] wdata_m_c;
  logic [31:0] lo_word_c;
  logic [31:0] hi_word_c;

  // Word address of a beat; beat 1 is the following word (wraps at 4 GiB).
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic beat);
    return {a[31:2], 2'b00} + (beat ? 32'd4 : 32'd0);
  endfunction

  // Byte enables of a beat: low part of the shifted mask, or the spill-over.
  function automatic logic [3:0] beat_be(input logic [3:0] mask, input logic [1:0] off,
                                         input logic beat);
    logic [7:0] wide;
    if (beat) wide = {4'b0000, mask} >> (3'd4 - {1'b0, off});
    else      wide = {4'b0000, mask} << off;
    return wide[3:0];
  endfunction

  // Store data of a beat, lane-steered to match beat_be.
  function automatic logic [31:0] beat_wdata(input logic [31:0] wd, input logic [1:0] off,
                                             input logic beat);
    logic [5:0] sh;
    sh = {1'b0, off, 3'b000};
    if (beat) return wd >> (6'd32 - sh);
    return wd << sh;
  endfunction

  // Shift the two-word window down to the access byte, then extend.
  function automatic logic [31:0] load_ext(input logic [63:0] dw, input logic [1:0] off,
                                           input logic [2:0] lt);
    logic [63:0] sh;
    sh = dw >> {off, 3'b000};
    case (lt)
      LT_LB:   return {{24{sh[7]}}, sh[7:0]};
      LT_LH:   return {{16{sh[15]}}, sh[15:0]};
      LT_LW:   return sh[31:0];
      LT_LBU:  return {24'h000000, sh[7:0]};
      LT_LHU:  return {16'h0000, sh[15:0]};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Decode size mask, legality and misalignment of the incoming request.
  always_comb begin
    mask_c    = 4'b0000;
    illegal_c = 1'b0;
    if (req_write) begin
      case (store_type)
        2'b00:   mask_c = 4'b0001;
        2'b01:   mask_c = 4'b0011;
        2'b10:   mask_c = 4'b1111;
        default: illegal_c = 1'b1;
      endcase
    end else begin
      case (load_type)
        LT_LB, LT_LBU: mask_c = 4'b0001;
        LT_LH, LT_LHU: mask_c = 4'b0011;
        LT_LW:         mask_c = 4'b1111;
        default:       illegal_c = 1'b1;
      endcase
    end
    spill_c    = {4'b0000, mask_c} << addr[1:0];
    misalign_c = |spill_c[7:4];
    wdata_m_c  = wdata & {{8{mask_c[3]}}, {8{mask_c[2]}}, {8{mask_c[1]}}, {8{mask_c[0]}}};
    lo_word_c  = beat_q ? word0_q : bus_rdata;
    hi_word_c  = beat_q ? bus_rdata : 32'h0000_0000;
  end

  // Access sequencer: state, beat, wait counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= 1'b0;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      ltype_q     <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      mask_q      <= 4'b0000;
      misalign_q  <= 1'b0;
      word0_q     <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'b0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            ltype_q    <= load_type;
            addr_q     <= addr;
            wdata_q    <= wdata_m_c;
            mask_q     <= mask_c;
            misalign_q <= misalign_c;
            word0_q    <= 32'h0;
            beat_q     <= 1'b0;
            cnt_q      <= '0;
            if (illegal_c) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else begin
              state_q     <= S_ADDR;
              bus_req_q   <= 1'b1;
              bus_we_q    <= req_write;
              bus_addr_q  <= beat_addr(addr, 1'b0);
              bus_be_q    <= beat_be(mask_c, addr[1:0], 1'b0);
              bus_wdata_q <= beat_wdata(wdata_m_c, addr[1:0], 1'b0);
            end
          end
        end
        S_ADDR: begin
          if (bus_gnt) begin
            state_q   <= S_RESP;
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= S_DONE;
            bus_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            rdata_q   <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus_rvalid) begin
            if (bus_err) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else if (!beat_q && misalign_q) begin
              word0_q     <= bus_rdata;
              beat_q      <= 1'b1;
              cnt_q       <= '0;
              state_q     <= S_ADDR;
              bus_req_q   <= 1'b1;
              bus_addr_q  <= beat_addr(addr_q, 1'b1);
              bus_be_q    <= beat_be(mask_q, addr_q[1:0], 1'b1);
              bus_wdata_q <= beat_wdata(wdata_q, addr_q[1:0], 1'b1);
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= write_q ? 32'h0 : load_ext({hi_word_c, lo_word_c}, addr_q[1:0], ltype_q);
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall while a request is pending or in flight; never during the done cycle.
  assign busy = ~rst & (((state_q == S_IDLE) & req_valid) | (state_q == S_ADDR) |
                        (state_q == S_RESP));

  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: expected beats and results are queued
// when a request is driven and checked as the DUT issues beats and done.
module tb_lsu_bus_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } res_t;

  beat_t       exp_beats[$];
  res_t        exp_res[$];
  logic [31:0] mem [logic [31:0]];
  int          n_cmp = 0;
  int          n_bad = 0;

  lsu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .load_type(load_type), .store_type(store_type), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_err(bus_err),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {wa[15:0] ^ 16'h3C5A, ~wa[15:0]};
  endfunction

  task automatic pb(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                    input logic we);
    beat_t b;
    b.addr = a; b.be = be; b.wdata = wd; b.we = we;
    exp_beats.push_back(b);
  endtask

  task automatic pr(input logic [31:0] rd, input logic e);
    res_t r;
    r.rdata = rd; r.err = e;
    exp_res.push_back(r);
  endtask

  // Byte-by-byte reference: which word and lane each access byte lands in.
  task automatic push_model(input logic w, input logic [2:0] lt, input logic [1:0] st,
                            input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic [31:0] v, ba, wa0, word;
    beat_t b0, b1;
    bit two;
    if (w) n = (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : (st == 2'd2) ? 4 : 0;
    else   n = (lt == 3'd0 || lt == 3'd3) ? 1 : (lt == 3'd1 || lt == 3'd4) ? 2 :
               (lt == 3'd2) ? 4 : 0;
    if (n == 0) begin
      pr(32'h0, 1'b1);
      return;
    end
    wa0 = {a[31:2], 2'b00};
    b0.addr = wa0;          b0.be = 4'b0; b0.wdata = 32'h0; b0.we = w;
    b1.addr = wa0 + 32'd4;  b1.be = 4'b0; b1.wdata = 32'h0; b1.we = w;
    two = 0;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      word = mem_rd({ba[31:2], 2'b00});
      v[8*i +: 8] = word[8*ba[1:0] +: 8];
      if ({ba[31:2], 2'b00} == wa0) begin
        b0.be[ba[1:0]] = 1'b1;
        b0.wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
      end else begin
        two = 1;
        b1.be[ba[1:0]] = 1'b1;
        b1.wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
    end
    exp_beats.push_back(b0);
    if (two) exp_beats.push_back(b1);
    if (w) pr(32'h0, 1'b0);
    else begin
      case (lt)
        3'd0:    pr({{24{v[7]}}, v[7:0]}, 1'b0);
        3'd1:    pr({{16{v[15]}}, v[15:0]}, 1'b0);
        3'd3:    pr({24'h0, v[7:0]}, 1'b0);
        3'd4:    pr({16'h0, v[15:0]}, 1'b0);
        default: pr(v, 1'b0);
      endcase
    end
  endtask

  // Drive one request and act as the bus slave until done (called at negedge).
  task automatic access(input logic w, input logic [2:0] lt, input logic [1:0] st,
                        input logic [31:0] a, input logic [31:0] wd, input int gnt_wait,
                        input bit err_b0, input bit no_rv, input int exp_lat);
    int cyc, wait_n, beat;
    bit in_resp, seen;
    beat_t cur, eb;
    res_t er;
    logic [31:0] h_rd;
    logic h_err;
    req_valid = 1'b1; req_write = w; load_type = lt; store_type = st; addr = a; wdata = wd;
    #1 chk("busy_req", busy, 1);
    @(posedge clk);
    cyc = 0; wait_n = 0; beat = 0; in_resp = 0; seen = 0;
    cur.addr = 32'h0; cur.be = 4'b0; cur.wdata = 32'h0; cur.we = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'hDEAD_BEEF;
      if (done) begin
        chk("busy_in_done", busy, 0);
        if (exp_res.size() == 0) chk("res_queue", 32'(exp_res.size()), 1);
        else begin
          er = exp_res.pop_front();
          chk("rdata", rdata, er.rdata);
          chk("err", err, er.err);
        end
        if (exp_lat >= 0) chk("latency", cyc, exp_lat);
        else chk("timeout_latency", (cyc >= TO) ? 1 : 0, 1);
        chk("beats_left", 32'(exp_beats.size()), 0);
        exp_beats.delete();
        req_valid = 1'b0;
        break;
      end
      if (cyc > 4 * TO + 20) begin
        chk("done_seen", done, 1);
        req_valid = 1'b0;
        exp_beats.delete();
        exp_res.delete();
        break;
      end
      chk("busy_run", busy, 1);
      if (bus_req) begin
        if (!seen) begin
          seen = 1; wait_n = 0;
          if (exp_beats.size() == 0) chk("beat_queue", 32'(exp_beats.size()), 1);
          else begin
            eb = exp_beats.pop_front();
            chk("bus_addr", bus_addr, eb.addr);
            chk("bus_be", 32'(bus_be), 32'(eb.be));
            chk("bus_we", bus_we, eb.we);
            if (eb.we) chk("bus_wdata", bus_wdata, eb.wdata);
          end
          cur.addr = bus_addr; cur.be = bus_be; cur.wdata = bus_wdata; cur.we = bus_we;
        end else begin
          chk("hold_addr", bus_addr, cur.addr);
          chk("hold_be", 32'(bus_be), 32'(cur.be));
          chk("hold_wdata", bus_wdata, cur.wdata);
          chk("hold_we", bus_we, cur.we);
        end
        if (wait_n == gnt_wait) begin
          bus_gnt = 1'b1; in_resp = 1; seen = 0;
        end else begin
          wait_n++;
          bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'h5A5A_5A5A;
        end
      end else if (in_resp && !no_rv) begin
        bus_rvalid = 1'b1;
        bus_rdata  = mem_rd(cur.addr);
        bus_err    = err_b0 && (beat == 0);
        in_resp    = 0;
        beat++;
      end
    end
    h_rd = rdata; h_err = err;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    chk("done_pulse", done, 0);
    chk("hold_rdata", rdata, h_rd);
    chk("hold_err", err, h_err);
  endtask

  // Reset while waiting for the response; late bus handshakes must be ignored.
  task automatic reset_mid();
    req_valid = 1'b1; req_write = 1'b0; load_type = 3'd2; store_type = 2'd0;
    addr = 32'h300; wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pre_req", bus_req, 1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("rst_in_resp_req", bus_req, 0);
    chk("rst_in_resp_busy", busy, 1);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_req", bus_req, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_addr", bus_addr, 0);
    chk("rst_mid_be", 32'(bus_be), 0);
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_err", err, 0);
    for (int i = 0; i < 3; i++) begin
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("late_done", done, 0);
      chk("late_req", bus_req, 0);
      chk("late_rdata", rdata, 0);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  initial begin
    logic w;
    logic [2:0] lt;
    logic [1:0] st;
    logic [31:0] a, wd;
    int gw, nb;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; load_type = 3'd0; store_type = 2'd0;
    addr = 32'h0; wdata = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_be", 32'(bus_be), 0);

    // LW aligned, immediate grant
    mem[32'h100] = 32'h8899_AABB;
    pb(32'h100, 4'b1111, 32'h0, 1'b0); pr(32'h8899_AABB, 1'b0);
    access(1'b0, 3'd2, 2'd0, 32'h100, 32'h0, 0, 0, 0, 3);

    // LH / LHU straddling a word boundary
    mem[32'h100] = 32'hCC00_0000;
    mem[32'h104] = 32'h0000_00FF;
    pb(32'h100, 4'b1000, 32'h0, 1'b0); pb(32'h104, 4'b0001, 32'h0, 1'b0);
    pr(32'hFFFF_FFCC, 1'b0);
    access(1'b0, 3'd1, 2'd0, 32'h103, 32'h0, 0, 0, 0, 5);
    pb(32'h100, 4'b1000, 32'h0, 1'b0); pb(32'h104, 4'b0001, 32'h0, 1'b0);
    pr(32'h0000_FFCC, 1'b0);
    access(1'b0, 3'd4, 2'd0, 32'h103, 32'h0, 0, 0, 0, 5);

    // SB into lane 2
    pb(32'h200, 4'b0100, 32'h0078_0000, 1'b1); pr(32'h0, 1'b0);
    access(1'b1, 3'd0, 2'd0, 32'h202, 32'h1234_5678, 0, 0, 0, 3);

    // SW misaligned by one byte
    pb(32'h7FC, 4'b1110, 32'hBBCC_DD00, 1'b1); pb(32'h800, 4'b0001, 32'h0000_00AA, 1'b1);
    pr(32'h0, 1'b0);
    access(1'b1, 3'd0, 2'd2, 32'h7FD, 32'hAABB_CCDD, 0, 0, 0, 5);

    // Grant withheld three cycles, stray rvalid meanwhile
    mem[32'h100] = 32'h8899_AABB;
    pb(32'h100, 4'b1111, 32'h0, 1'b0); pr(32'h8899_AABB, 1'b0);
    access(1'b0, 3'd2, 2'd0, 32'h100, 32'h0, 3, 0, 0, 6);

    // Response never arrives
    pb(32'h100, 4'b1111, 32'h0, 1'b0); pr(32'h0, 1'b1);
    access(1'b0, 3'd2, 2'd0, 32'h100, 32'h0, 0, 0, 1, -1);

    // Bus error on beat 0 of a misaligned load: no second beat
    pb(32'h100, 4'b1000, 32'h0, 1'b0); pr(32'h0, 1'b1);
    access(1'b0, 3'd1, 2'd0, 32'h103, 32'h0, 0, 1, 0, 3);

    // Illegal load and store types
    pr(32'h0, 1'b1);
    access(1'b0, 3'd5, 2'd0, 32'h100, 32'h0, 0, 0, 0, 1);
    pr(32'h0, 1'b1);
    access(1'b1, 3'd0, 2'd3, 32'h100, 32'h0, 0, 0, 0, 1);

    reset_mid();

    // Address wrap on the second beat
    push_model(1'b1, 3'd0, 2'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    access(1'b1, 3'd0, 2'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, 0, 0, 5);

    // Random mix of legal accesses
    for (int k = 0; k < 24; k++) begin
      w  = 1'($urandom_range(0, 1));
      lt = 3'($urandom_range(0, 4));
      st = 2'($urandom_range(0, 2));
      a  = $urandom;
      wd = $urandom;
      gw = $urandom_range(0, 2);
      push_model(w, lt, st, a, wd);
      nb = exp_beats.size();
      access(w, lt, st, a, wd, gw, 0, 0, nb * (2 + gw) + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
